readout_bus_arbiter: RTL and testbench

N-channel arbiter and sequencer for the shared sensor row/ADC control bus. Each readout engine (full-resolution, 1-bit, and future variants) requests the bus with a start pulse. The arbiter queues requests and grants one engine at a time using fixed or round-robin priority. It then launches the engine, muxes that engine's control outputs onto the pad bus through a register stage, and inserts a programmable guard interval in which the bus is parked at a safe idle pattern. It sits between the per-mode readout engines and the sensor pads and replaces the earlier two-way busy-selected mux.

---
 rtl/readout_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_readout_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_bus_arbiter.sv
// rtl/readout_bus_arbiter.sv - queued arbiter/sequencer driving the shared sensor row/ADC control bus
module readout_bus_arbiter #(
  parameter int                NUM_CH    = 4,
  parameter int                ROW_W     = 9,
  parameter int                CTRL_W    = 13,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = 13'h0040,
  parameter int                TO_W      = 16
) (
  input  logic                     TX_CLK,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        trig_i,
  input  logic                     prio_mode,
  input  logic [7:0]               guard_cycles,
  input  logic [TO_W-1:0]          start_timeout,
  input  logic                     err_clr,
  input  logic [NUM_CH-1:0]        ch_busy_i,
  input  logic [NUM_CH*ROW_W-1:0]  ch_rowadd_i,
  input  logic [NUM_CH*CTRL_W-1:0] ch_ctrl_i,
  output logic [NUM_CH-1:0]        ch_trigger_o,
  output logic [NUM_CH-1:0]        grant_o,
  output logic [ROW_W-1:0]         ROWADD,
  output logic [CTRL_W-1:0]        ctrl_o,
  output logic                     busy_o,
  output logic                     overrun_err,
  output logic                     timeout_err,
  output logic                     protocol_err
);

  localparam int G_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_GUARD} state_t;

  state_t              state, state_nxt;
  logic [G_W-1:0]      g_idx, g_nxt, last_g, win_idx;
  logic [NUM_CH-1:0]   pending, g_oh, win_oh;
  logic [TO_W-1:0]     launch_cnt;
  logic [7:0]          guard_cnt;
  logic                found, launch_go, timeout_hit, bus_live;
  logic                overrun_evt, timeout_evt, protocol_evt;
  logic [ROW_W-1:0]    row_d;
  logic [CTRL_W-1:0]   ctrl_d;

  // Winner = pending channel with the smallest distance from the search start.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && pending[j] &&
            ((prio_mode ? ((j + NUM_CH - 1 - int'(last_g)) % NUM_CH) : j) == k)) begin
          found   = 1'b1;
          win_idx = G_W'(j);
        end
      end
    end
  end

  always_comb begin
    g_oh   = '0;
    win_oh = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      g_oh[j]   = (int'(g_idx) == j);
      win_oh[j] = (int'(win_idx) == j);
    end
  end

  assign launch_go   = (state == S_IDLE) && (|pending);
  assign g_nxt       = launch_go ? win_idx : g_idx;
  assign timeout_hit = (start_timeout != '0) && (launch_cnt == start_timeout - TO_W'(1));

  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      g_idx      <= '0;
      last_g     <= G_W'(NUM_CH - 1);
      launch_cnt <= '0;
      guard_cnt  <= '0;
    end else begin
      state <= state_nxt;
      g_idx <= g_nxt;
      if (state == S_RUN && state_nxt == S_GUARD)
        last_g <= g_idx;
      if (state != S_LAUNCH)
        launch_cnt <= '0;
      else if (launch_cnt != '1)
        launch_cnt <= launch_cnt + TO_W'(1);
      // Guard length is latched on entry so software may change it mid-interval.
      if (state != S_GUARD && state_nxt == S_GUARD)
        guard_cnt <= (guard_cycles > 8'd1) ? guard_cycles - 8'd1 : 8'd0;
      else if (state == S_GUARD && guard_cnt != 8'd0)
        guard_cnt <= guard_cnt - 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|pending) state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        if (ch_busy_i[g_idx])  state_nxt = S_RUN;
        else if (timeout_hit)  state_nxt = S_GUARD;
      end
      S_RUN:    if (!ch_busy_i[g_idx]) state_nxt = S_GUARD;
      S_GUARD:  if (guard_cnt == 8'd0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_o      = '0;
    ch_trigger_o = '0;
    busy_o       = (state != S_IDLE) || (|pending);
    if (state == S_LAUNCH || state == S_RUN)
      grant_o = g_oh;
    if (state == S_LAUNCH && launch_cnt == '0)
      ch_trigger_o = g_oh;
    // Bus register follows the next owner so the pads lag the engine by one cycle.
    bus_live = (state_nxt == S_LAUNCH) || (state_nxt == S_RUN);
    row_d    = '0;
    ctrl_d   = IDLE_CTRL;
    for (int j = 0; j < NUM_CH; j++) begin
      if (bus_live && int'(g_nxt) == j) begin
        row_d  = ch_rowadd_i[j*ROW_W +: ROW_W];
        ctrl_d = ch_ctrl_i[j*CTRL_W +: CTRL_W];
      end
    end
  end

  assign overrun_evt  = |(trig_i & pending);
  assign timeout_evt  = (state == S_LAUNCH) && (state_nxt == S_GUARD);
  assign protocol_evt = (state == S_IDLE) ? (|ch_busy_i) : (|(ch_busy_i & ~g_oh));

  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      ROWADD       <= '0;
      ctrl_o       <= IDLE_CTRL;
      overrun_err  <= 1'b0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      pending      <= (pending & ~(launch_go ? win_oh : '0)) | trig_i;
      ROWADD       <= row_d;
      ctrl_o       <= ctrl_d;
      overrun_err  <= overrun_evt  | (overrun_err  & ~err_clr);
      timeout_err  <= timeout_evt  | (timeout_err  & ~err_clr);
      protocol_err <= protocol_evt | (protocol_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_readout_bus_arbiter.sv
// tb/tb_readout_bus_arbiter.sv - self-checking bench for readout_bus_arbiter
module tb_readout_bus_arbiter;

  localparam logic [12:0] IDLE = 13'h0040;

  logic        TX_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  trig_i = '0;
  logic        prio_mode = 1'b0;
  logic [7:0]  guard_cycles = 8'd3;
  logic [15:0] start_timeout = '0;
  logic        err_clr = 1'b0;
  logic [3:0]  ch_busy_i = '0;
  logic [35:0] ch_rowadd_i = '0;
  logic [51:0] ch_ctrl_i = '0;
  logic [3:0]  ch_trigger_o, grant_o;
  logic [8:0]  ROWADD;
  logic [12:0] ctrl_o;
  logic        busy_o, overrun_err, timeout_err, protocol_err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  readout_bus_arbiter #(.NUM_CH(4), .ROW_W(9), .CTRL_W(13), .IDLE_CTRL(13'h0040), .TO_W(16)) dut (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .trig_i(trig_i), .prio_mode(prio_mode),
    .guard_cycles(guard_cycles), .start_timeout(start_timeout), .err_clr(err_clr),
    .ch_busy_i(ch_busy_i), .ch_rowadd_i(ch_rowadd_i), .ch_ctrl_i(ch_ctrl_i),
    .ch_trigger_o(ch_trigger_o), .grant_o(grant_o), .ROWADD(ROWADD), .ctrl_o(ctrl_o),
    .busy_o(busy_o), .overrun_err(overrun_err), .timeout_err(timeout_err),
    .protocol_err(protocol_err)
  );

  always #5 TX_CLK = ~TX_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Engine data changes every cycle so the one-cycle bus lag is observable.
  int cyc = 0;
  bit fix2 = 1'b0;
  always @(negedge TX_CLK) begin : data_drv
    cyc++;
    for (int c = 0; c < 4; c++) begin
      ch_rowadd_i[c*9 +: 9]   = 9'((cyc * 7 + c * 37) % 512);
      ch_ctrl_i[c*13 +: 13]   = 13'((cyc * 13 + c * 341) % 8192);
    end
    if (fix2) begin
      ch_rowadd_i[18 +: 9] = 9'd300;
      ch_ctrl_i[26 +: 13]  = 13'h1ABC;
    end
  end

  // Engine responders: raise busy on their launch pulse for eng_len cycles.
  int         eng_cnt [4] = '{0, 0, 0, 0};
  int         eng_len = 10;
  logic [3:0] eng_en = 4'b1111;
  logic [3:0] extra_busy = '0;
  always @(negedge TX_CLK) begin : engines
    logic [3:0] b;
    for (int c = 0; c < 4; c++) begin
      if (!rst_n) eng_cnt[c] = 0;
      else if (ch_trigger_o[c] && eng_en[c]) eng_cnt[c] = eng_len;
      else if (eng_cnt[c] > 0) eng_cnt[c]--;
      b[c] = (eng_cnt[c] > 0);
    end
    ch_busy_i = b | extra_busy;
  end

  // Reference model: bus ownership phases (0 idle, 1 launch, 2 run, 3 guard).
  int          m_phase, m_owner, m_last, m_cnt, m_glen;
  bit [3:0]    m_pend;
  bit [8:0]    m_row;
  bit [12:0]   m_ctrl;
  bit          m_ovr, m_tmo, m_prot;

  function automatic int pick(input bit [3:0] p, input bit rr, input int last);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = rr ? (last + 1 + k) % 4 : k;
      if (p[c]) return c;
    end
    return 0;
  endfunction

  always @(posedge TX_CLK or negedge rst_n) begin : model
    int np, no;
    bit oe, pe, te;
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_last = 3; m_cnt = 0; m_glen = 1; m_pend = '0;
      m_row = '0; m_ctrl = IDLE; m_ovr = 0; m_tmo = 0; m_prot = 0;
    end else begin
      np = m_phase; no = m_owner; te = 0;
      oe = |(trig_i & m_pend);
      pe = (m_phase == 0) ? |ch_busy_i : |(ch_busy_i & ~(4'b0001 << m_owner));
      case (m_phase)
        0: if (m_pend != 0) begin
             no = pick(m_pend, prio_mode, m_last); np = 1; m_cnt = 0; m_pend[no] = 1'b0;
           end
        1: if (ch_busy_i[m_owner]) np = 2;
           else if (start_timeout != 0 && m_cnt + 1 == int'(start_timeout)) begin np = 3; te = 1; end
           else m_cnt++;
        2: if (!ch_busy_i[m_owner]) begin np = 3; m_last = m_owner; end
        default: if (m_cnt + 1 >= m_glen) np = 0; else m_cnt++;
      endcase
      if (np == 3 && m_phase != 3) begin
        m_glen = (guard_cycles == 0) ? 1 : int'(guard_cycles);
        m_cnt  = 0;
      end
      m_pend = m_pend | trig_i;
      m_ovr  = oe | (m_ovr & !err_clr);
      m_tmo  = te | (m_tmo & !err_clr);
      m_prot = pe | (m_prot & !err_clr);
      m_phase = np; m_owner = no;
      if (np == 1 || np == 2) begin
        m_row  = ch_rowadd_i[no*9 +: 9];
        m_ctrl = ch_ctrl_i[no*13 +: 13];
      end else begin
        m_row = '0; m_ctrl = IDLE;
      end
    end
  end

  always @(negedge TX_CLK) begin : compare
    logic [3:0] eg;
    if (cmp_en) begin
      eg = (m_phase == 1 || m_phase == 2) ? (4'b0001 << m_owner) : 4'b0000;
      chk("grant", grant_o, eg);
      chk("trigger", ch_trigger_o, (m_phase == 1 && m_cnt == 0) ? eg : 4'b0000);
      chk("rowadd", ROWADD, m_row);
      chk("ctrl", ctrl_o, m_ctrl);
      chk("busy", busy_o, (m_phase != 0 || m_pend != 0));
      chk("overrun", overrun_err, m_ovr);
      chk("timeout", timeout_err, m_tmo);
      chk("protocol", protocol_err, m_prot);
    end
  end

  // Observation of grant order, gaps and launch counts for the literal checks.
  int         gq[$];
  int         last_gap = 0, zero_run = 0, g0_cycles = 0;
  int         tcnt [4] = '{0, 0, 0, 0};
  logic [3:0] prev_g = '0;
  always @(negedge TX_CLK) begin : monitor
    if (grant_o != 0 && prev_g == 0) begin
      for (int c = 0; c < 4; c++) if (grant_o[c]) gq.push_back(c);
      last_gap = zero_run;
    end
    zero_run = (grant_o == 0) ? zero_run + 1 : 0;
    if (grant_o == 4'b0001) g0_cycles++;
    for (int c = 0; c < 4; c++) tcnt[c] += int'(ch_trigger_o[c]);
    prev_g = grant_o;
  end

  task automatic do_reset();
    @(negedge TX_CLK);
    #2 rst_n = 1'b0;
    trig_i = '0; err_clr = 1'b0; extra_busy = '0;
    @(negedge TX_CLK);
    @(negedge TX_CLK);
    #2 rst_n = 1'b1;
    gq.delete();
    g0_cycles = 0;
    for (int c = 0; c < 4; c++) tcnt[c] = 0;
  endtask

  task automatic pulse(input logic [3:0] t);
    @(negedge TX_CLK); trig_i = t;
    @(negedge TX_CLK); trig_i = '0;
  endtask

  task automatic wait_grant(input logic [3:0] g, input string name);
    int n = 0;
    while (grant_o !== g && n < 200) begin @(negedge TX_CLK); n++; end
    chk(name, grant_o, g);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge TX_CLK);
    while (busy_o !== 1'b0 && n < 300) begin @(negedge TX_CLK); n++; end
    chk(name, busy_o, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (2) @(negedge TX_CLK);
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_trigger", ch_trigger_o, 4'b0000);
    chk("rst_rowadd", ROWADD, 9'd0);
    chk("rst_ctrl", ctrl_o, 13'h0040);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_errs", {overrun_err, timeout_err, protocol_err}, 3'b000);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Fixed priority, two simultaneous requests, guard of 3.
    prio_mode = 1'b0; guard_cycles = 8'd3; eng_len = 10;
    pulse(4'b0110);
    @(negedge TX_CLK);
    chk("latency_trigger", ch_trigger_o, 4'b0010);
    wait_idle("t1_idle");
    chk("t1_count", gq.size(), 2);
    chk("t1_first", gq[0], 1);
    chk("t1_second", gq[1], 2);
    chk("t1_gap", last_gap, 4);

    // Round-robin with every channel re-requesting continuously.
    do_reset();
    prio_mode = 1'b1; guard_cycles = 8'd1; eng_len = 2;
    @(negedge TX_CLK); trig_i = 4'b1111;
    for (int n = 0; n < 400 && gq.size() < 5; n++) @(negedge TX_CLK);
    trig_i = '0;
    wait_idle("rr_idle");
    chk("rr_g0", gq[0], 0);
    chk("rr_g1", gq[1], 1);
    chk("rr_g2", gq[2], 2);
    chk("rr_g3", gq[3], 3);
    chk("rr_g4", gq[4], 0);
    chk("rr_overrun", overrun_err, 1'b1);

    // Bus mux contents for channel 2 and parking after the run.
    do_reset();
    prio_mode = 1'b0; guard_cycles = 8'd2; eng_len = 4; fix2 = 1'b1;
    pulse(4'b0100);
    wait_grant(4'b0100, "mux_grant");
    chk("mux_ctrl", ctrl_o, 13'h1ABC);
    chk("mux_row", ROWADD, 9'd300);
    for (int n = 0; n < 50 && grant_o != 0; n++) @(negedge TX_CLK);
    chk("park_ctrl", ctrl_o, 13'h0040);
    chk("park_row", ROWADD, 9'd0);
    wait_idle("mux_idle");
    fix2 = 1'b0;

    // Launch timeout: channel 0 never responds, channel 1 is served next.
    do_reset();
    start_timeout = 16'd5; eng_en = 4'b1110; eng_len = 3;
    pulse(4'b0011);
    wait_grant(4'b0010, "to_next_grant");
    chk("to_first", gq[0], 0);
    chk("to_launch_len", g0_cycles, 5);
    chk("to_flag", timeout_err, 1'b1);
    wait_idle("to_idle");
    @(negedge TX_CLK); err_clr = 1'b1;
    @(negedge TX_CLK); err_clr = 1'b0;
    chk("to_clear", timeout_err, 1'b0);
    start_timeout = '0; eng_en = 4'b1111;

    // Overrun: channel 1 requested twice while channel 0 holds the bus.
    do_reset();
    eng_len = 8; guard_cycles = 8'd1;
    pulse(4'b0001);
    wait_grant(4'b0001, "ovr_grant");
    pulse(4'b0010);
    pulse(4'b0010);
    chk("ovr_flag", overrun_err, 1'b1);
    wait_idle("ovr_idle");
    chk("ovr_launches", tcnt[1], 1);

    // Protocol: a foreign busy bit while channel 0 is running.
    do_reset();
    pulse(4'b0001);
    wait_grant(4'b0001, "prot_grant");
    repeat (2) @(negedge TX_CLK);
    extra_busy = 4'b1000;
    repeat (2) @(negedge TX_CLK);
    extra_busy = '0;
    @(negedge TX_CLK);
    chk("prot_flag", protocol_err, 1'b1);
    chk("prot_grant_kept", grant_o, 4'b0001);
    wait_idle("prot_idle");

    // Asynchronous reset in the middle of a run.
    do_reset();
    eng_len = 10;
    pulse(4'b0010);
    wait_grant(4'b0010, "ar_grant");
    repeat (3) @(negedge TX_CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", grant_o, 4'b0000);
    chk("ar_trigger", ch_trigger_o, 4'b0000);
    chk("ar_rowadd", ROWADD, 9'd0);
    chk("ar_ctrl", ctrl_o, 13'h0040);
    chk("ar_busy", busy_o, 1'b0);
    repeat (2) @(negedge TX_CLK);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge TX_CLK);
    chk("ar_post_busy", busy_o, 1'b0);
    chk("ar_post_grant", grant_o, 4'b0000);

    repeat (3) @(negedge TX_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
